// File: rtl/pc_gen.sv
// Fetch program counter: reset vector, sequential step, branch/flush redirect and a
// pending slot for branches resolved under stall. Define PC_MISALIGN_EN to pass misaligned
// redirects through unmodified and flag them on misalign_o.
module pc_gen #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STALL_W      = 6,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int unsigned STEP         = 4,
    parameter int unsigned ALIGN_BITS   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic [ADDR_W-1:0]  pc_plus_o,
    output logic               pend_o,
    output logic               misalign_o
);

    localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              redirect;
    logic [ADDR_W-1:0] redir_addr;
    logic [ADDR_W-1:0] load_addr;

    // Only the PC stage bit of the stall vector matters here.
    logic unused_stall;
    assign unused_stall = ^stall[STALL_W-1:1];

    assign pc_plus_o = pc_q + ADDR_W'(STEP);

    always_comb begin
        redirect   = 1'b0;
        redir_addr = pc_q;
        pend_d     = pend_q;
        tgt_d      = tgt_q;
        if (ce_q) begin
            if (flush) begin
                redirect   = 1'b1;
                redir_addr = new_pc;
                pend_d     = 1'b0;
            end else if (stall[0]) begin
                if (branch_flag_i) begin
                    tgt_d  = branch_target_address_i;
                    pend_d = 1'b1;
                end
            end else if (pend_q) begin
                // The captured branch is older than any branch arriving now.
                redirect   = 1'b1;
                redir_addr = tgt_q;
                pend_d     = 1'b0;
            end else if (branch_flag_i) begin
                redirect   = 1'b1;
                redir_addr = branch_target_address_i;
            end
        end
    end

`ifdef PC_MISALIGN_EN
    logic misalign_q;
    assign load_addr  = redir_addr;
    assign misalign_o = misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect && |(redir_addr & AlignMask);
        end
    end
`else
    assign load_addr  = redir_addr & ~AlignMask;
    assign misalign_o = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = load_addr;
        end else if (ce_q && !stall[0]) begin
            pc_d = pc_plus_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_VECTOR;
            ce_q   <= 1'b0;
            pend_q <= 1'b0;
            tgt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            ce_q   <= 1'b1;
            pend_q <= pend_d;
            tgt_q  <= tgt_d;
        end
    end

    assign pc     = pc_q;
    assign ce     = ce_q;
    assign pend_o = pend_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: each driven cycle pushes its expected post-edge state,
// which is popped and compared one time unit after the rising edge.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = '0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic [31:0] pc;
    logic        ce;
    logic [31:0] pc_plus_o;
    logic        pend_o;
    logic        misalign_o;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

`ifdef PC_MISALIGN_EN
    localparam logic [31:0] MisPc  = 32'h0000_0402;
    localparam logic        MisBit = 1'b1;
`else
    localparam logic [31:0] MisPc  = 32'h0000_0400;
    localparam logic        MisBit = 1'b0;
`endif

    pc_gen dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .pc                      (pc),
        .ce                      (ce),
        .pc_plus_o               (pc_plus_o),
        .pend_o                  (pend_o),
        .misalign_o              (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, record the expected state after the edge, then compare.
    task automatic cyc(input logic r, input logic s0, input logic br, input logic [31:0] tgt,
                       input logic fl, input logic [31:0] npc, input logic [31:0] epc,
                       input logic ece, input logic epend, input logic emis);
        exp_t e;
        rst                     = r;
        stall                   = {5'b0, s0};
        branch_flag_i           = br;
        branch_target_address_i = tgt;
        flush                   = fl;
        new_pc                  = npc;
        sb.push_back('{pc: epc, ce: ece, pend: epend, mis: emis});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("pc", pc, e.pc);
            check("ce", {31'b0, ce}, {31'b0, e.ce});
            check("pend", {31'b0, pend_o}, {31'b0, e.pend});
            check("misalign", {31'b0, misalign_o}, {31'b0, e.mis});
            if (e.ce) check("pc_plus", pc_plus_o, e.pc + 32'd4);
        end
    endtask

    initial begin
        // Reset held three cycles
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        // First fetch at reset vector, then sequential
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h4, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h8, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'hC, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h10, 1, 0, 0);
        // Branch with no stall
        cyc(0, 0, 1, 32'h200, 0, 0, 32'h200, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h204, 1, 0, 0);
        cyc(0, 0, 1, 32'h20, 0, 0, 32'h20, 1, 0, 0);
        // Branch captured during a 3-cycle stall
        cyc(0, 1, 1, 32'h300, 0, 0, 32'h20, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 32'h20, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 32'h20, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h300, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h304, 1, 0, 0);
        // Flush beats stall and drops pending
        cyc(0, 1, 1, 32'h300, 0, 0, 32'h304, 1, 1, 0);
        cyc(0, 1, 0, 0, 1, 32'h8000_0180, 32'h8000_0180, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 32'h8000_0180, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 32'h8000_0180, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h8000_0184, 1, 0, 0);
        // Pending wins over a simultaneous fresh branch
        cyc(0, 1, 1, 32'h500, 0, 0, 32'h8000_0184, 1, 1, 0);
        cyc(0, 0, 1, 32'h600, 0, 0, 32'h500, 1, 0, 0);
        // Newer branch during stall overwrites older pending
        cyc(0, 1, 1, 32'h700, 0, 0, 32'h500, 1, 1, 0);
        cyc(0, 1, 1, 32'h740, 0, 0, 32'h500, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h740, 1, 0, 0);
        // Wrap-around
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0, 0);
        check("pc_plus_wrap", pc_plus_o, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
        // Misaligned branch
        cyc(0, 0, 1, 32'h402, 0, 0, MisPc, 1, 0, MisBit);
        cyc(0, 0, 0, 0, 0, 0, MisPc + 32'd4, 1, 0, 0);
        // Reset mid-stall with a pending branch: no redirect afterwards
        cyc(0, 1, 1, 32'h900, 0, 0, MisPc + 32'd4, 1, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h4, 1, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
